// File: rtl/alu_issue_stage_pkg.sv
// ----------------------------------------------------------------------------
// alu_pkg : shared types and constants for the ALU issue/writeback stage
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package alu_pkg;

    localparam int XLEN  = 32;
    localparam int NREGS = 8;
    localparam int NOPS  = 9;
    localparam int AW    = $clog2(NREGS);

    typedef enum logic [3:0] {
        OP_ADD = 4'd0,
        OP_SUB = 4'd1,
        OP_AND = 4'd2,
        OP_OR  = 4'd3,
        OP_XOR = 4'd4,
        OP_SRL = 4'd5,
        OP_SLL = 4'd6,
        OP_ROL = 4'd7,
        OP_ROR = 4'd8
    } alu_op_e;

    // op is kept as raw bits because illegal encodings must be representable
    typedef struct packed {
        logic [3:0]      op;
        logic [AW-1:0]   rd;
        logic [AW-1:0]   rs1;
        logic [AW-1:0]   rs2;
        logic            use_imm;
        logic [XLEN-1:0] imm;
        logic [4:0]      shamt;
    } issue_pkt_t;

    function automatic logic op_is_legal(input logic [3:0] op, input int nops);
        return int'({28'd0, op}) < nops;
    endfunction

endpackage

`default_nettype wire

// File: rtl/alu_issue_stage_if.sv
// ----------------------------------------------------------------------------
// alu_issue_stage_if : issue, ALU, writeback and debug signals of the stage
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface alu_issue_stage_if #(
    parameter int XLEN = 32,
    parameter int AW   = 3
);
    logic            in_valid;
    logic            in_ready;
    logic [3:0]      in_op;
    logic [AW-1:0]   in_rd;
    logic [AW-1:0]   in_rs1;
    logic [AW-1:0]   in_rs2;
    logic            in_use_imm;
    logic [XLEN-1:0] in_imm;
    logic [4:0]      in_shamt;

    logic [XLEN-1:0] alu_a;
    logic [XLEN-1:0] alu_b;
    logic [3:0]      alu_op_code;
    logic [4:0]      alu_shift_amount;
    logic [XLEN-1:0] alu_result;
    logic            alu_zero;

    logic            wb_valid;
    logic            wb_ready;
    logic [AW-1:0]   wb_rd;
    logic [XLEN-1:0] wb_data;
    logic            wb_zero;

    logic            err_illegal;
    logic [AW-1:0]   dbg_addr;
    logic [XLEN-1:0] dbg_data;

    modport slave (
        input  in_valid, in_op, in_rd, in_rs1, in_rs2, in_use_imm, in_imm, in_shamt,
        input  alu_result, alu_zero, wb_ready, dbg_addr,
        output in_ready, alu_a, alu_b, alu_op_code, alu_shift_amount,
        output wb_valid, wb_rd, wb_data, wb_zero, err_illegal, dbg_data
    );

    modport master (
        output in_valid, in_op, in_rd, in_rs1, in_rs2, in_use_imm, in_imm, in_shamt,
        output alu_result, alu_zero, wb_ready, dbg_addr,
        input  in_ready, alu_a, alu_b, alu_op_code, alu_shift_amount,
        input  wb_valid, wb_rd, wb_data, wb_zero, err_illegal, dbg_data
    );

endinterface

`default_nettype wire

// File: rtl/alu_issue_stage_regfile.sv
// ----------------------------------------------------------------------------
// alu_regfile : NREGS x XLEN register file, r0 hardwired to zero
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module alu_regfile #(
    parameter int NREGS = 8,
    parameter int XLEN  = 32
) (
    input  wire logic                     clk,
    input  wire logic                     rst,
    input  wire logic                     we,
    input  wire logic [$clog2(NREGS)-1:0] waddr,
    input  wire logic [XLEN-1:0]          wdata,
    input  wire logic [$clog2(NREGS)-1:0] raddr1,
    input  wire logic [$clog2(NREGS)-1:0] raddr2,
    input  wire logic [$clog2(NREGS)-1:0] dbg_addr,
    output logic      [XLEN-1:0]          rdata1,
    output logic      [XLEN-1:0]          rdata2,
    output logic      [XLEN-1:0]          dbg_data
);

    logic [XLEN-1:0] r_mem [NREGS];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                r_mem[i] <= '0;
            end
        end else if (we && (waddr != '0)) begin
            r_mem[waddr] <= wdata;
        end
    end

    assign rdata1   = (raddr1   == '0) ? '0 : r_mem[raddr1];
    assign rdata2   = (raddr2   == '0) ? '0 : r_mem[raddr2];
    assign dbg_data = (dbg_addr == '0) ? '0 : r_mem[dbg_addr];

endmodule

`default_nettype wire

// File: rtl/alu_issue_stage.sv
// ----------------------------------------------------------------------------
// alu_issue_stage : two-stage issue/writeback wrapper around a combinational ALU
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module alu_issue_stage import alu_pkg::*; #(
    parameter int NREGS = alu_pkg::NREGS,
    parameter int XLEN  = alu_pkg::XLEN,
    parameter int NOPS  = alu_pkg::NOPS
) (
    input wire logic         clk,
    input wire logic         rst,
    alu_issue_stage_if.slave bus
);

    localparam int AW = $clog2(NREGS);

    issue_pkt_t      w_pkt;
    logic            w_advance;
    logic            w_accept;
    logic            w_legal;
    logic            w_load_e;
    logic            w_rf_we;
    logic [XLEN-1:0] w_rf_rs1;
    logic [XLEN-1:0] w_rf_rs2;
    logic [XLEN-1:0] w_fwd_a;
    logic [XLEN-1:0] w_fwd_b;

    logic            r_valid_e;
    logic [AW-1:0]   r_rd_e;
    logic [XLEN-1:0] r_alu_a;
    logic [XLEN-1:0] r_alu_b;
    logic [3:0]      r_alu_op;
    logic [4:0]      r_alu_shamt;

    logic            r_wb_valid;
    logic [AW-1:0]   r_wb_rd;
    logic [XLEN-1:0] r_wb_data;
    logic            r_wb_zero;
    logic            r_err_illegal;

    assign w_pkt = '{op: bus.in_op, rd: bus.in_rd, rs1: bus.in_rs1, rs2: bus.in_rs2,
                     use_imm: bus.in_use_imm, imm: bus.in_imm, shamt: bus.in_shamt};

    assign w_advance = !r_wb_valid || bus.wb_ready;
    assign w_accept  = bus.in_valid && w_advance;
    assign w_legal   = op_is_legal(w_pkt.op, NOPS);
    assign w_load_e  = w_accept && w_legal;
    assign w_rf_we   = r_wb_valid && bus.wb_ready;

    alu_regfile #(
        .NREGS (NREGS),
        .XLEN  (XLEN)
    ) u_regfile (
        .clk      (clk),
        .rst      (rst),
        .we       (w_rf_we),
        .waddr    (r_wb_rd),
        .wdata    (r_wb_data),
        .raddr1   (w_pkt.rs1),
        .raddr2   (w_pkt.rs2),
        .dbg_addr (bus.dbg_addr),
        .rdata1   (w_rf_rs1),
        .rdata2   (w_rf_rs2),
        .dbg_data (bus.dbg_data)
    );

    // E's in-flight result is younger than W's, so it wins the forward
    always_comb begin
        w_fwd_a = w_rf_rs1;
        if (w_pkt.rs1 == '0) begin
            w_fwd_a = '0;
        end else if (r_valid_e && (r_rd_e == w_pkt.rs1)) begin
            w_fwd_a = bus.alu_result;
        end else if (r_wb_valid && (r_wb_rd == w_pkt.rs1)) begin
            w_fwd_a = r_wb_data;
        end
    end

    always_comb begin
        w_fwd_b = w_rf_rs2;
        if (w_pkt.use_imm) begin
            w_fwd_b = w_pkt.imm;
        end else if (w_pkt.rs2 == '0) begin
            w_fwd_b = '0;
        end else if (r_valid_e && (r_rd_e == w_pkt.rs2)) begin
            w_fwd_b = bus.alu_result;
        end else if (r_wb_valid && (r_wb_rd == w_pkt.rs2)) begin
            w_fwd_b = r_wb_data;
        end
    end

    // Operand registers hold when no packet loads, only the valid bit drops
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid_e   <= 1'b0;
            r_rd_e      <= '0;
            r_alu_a     <= '0;
            r_alu_b     <= '0;
            r_alu_op    <= '0;
            r_alu_shamt <= '0;
        end else if (w_advance) begin
            r_valid_e <= w_load_e;
            if (w_load_e) begin
                r_rd_e      <= w_pkt.rd;
                r_alu_a     <= w_fwd_a;
                r_alu_b     <= w_fwd_b;
                r_alu_op    <= w_pkt.op;
                r_alu_shamt <= w_pkt.shamt;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wb_valid <= 1'b0;
            r_wb_rd    <= '0;
            r_wb_data  <= '0;
            r_wb_zero  <= 1'b0;
        end else if (w_advance) begin
            r_wb_valid <= r_valid_e;
            r_wb_rd    <= r_rd_e;
            r_wb_data  <= bus.alu_result;
            r_wb_zero  <= bus.alu_zero;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err_illegal <= 1'b0;
        end else if (w_accept && !w_legal) begin
            r_err_illegal <= 1'b1;
        end
    end

    assign bus.in_ready         = w_advance;
    assign bus.alu_a            = r_alu_a;
    assign bus.alu_b            = r_alu_b;
    assign bus.alu_op_code      = r_alu_op;
    assign bus.alu_shift_amount = r_alu_shamt;
    assign bus.wb_valid         = r_wb_valid;
    assign bus.wb_rd            = r_wb_rd;
    assign bus.wb_data          = r_wb_data;
    assign bus.wb_zero          = r_wb_zero;
    assign bus.err_illegal      = r_err_illegal;

endmodule

`default_nettype wire

// File: tb/tb_alu_issue_stage.sv
// ----------------------------------------------------------------------------
// tb_alu_issue_stage : self-checking bench with an architectural reference model
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_alu_issue_stage;
    import alu_pkg::*;

    typedef struct packed {
        logic [2:0]  rd;
        logic [31:0] data;
        logic        zero;
    } wb_t;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    bit   rand_ready = 0;

    logic [31:0] m_regs [8];
    logic        m_err;
    logic [31:0] m_last_a;
    logic [31:0] m_last_b;
    wb_t         exp_q[$];
    wb_t         obs_q[$];

    alu_issue_stage_if #(.XLEN(32), .AW(3)) bus ();

    alu_issue_stage dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] alu_f(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input logic [4:0] sh);
        logic [63:0] t;
        case (op)
            OP_ADD: return a + b;
            OP_SUB: return a - b;
            OP_AND: return a & b;
            OP_OR:  return a | b;
            OP_XOR: return a ^ b;
            OP_SRL: return a >> sh;
            OP_SLL: return a << sh;
            OP_ROL: begin t = {a, a} << sh; return t[63:32]; end
            OP_ROR: begin t = {a, a} >> sh; return t[31:0]; end
            default: return 32'd0;
        endcase
    endfunction

    // External combinational ALU sitting between E and W
    always_comb begin
        bus.alu_result = alu_f(bus.alu_op_code, bus.alu_a, bus.alu_b, bus.alu_shift_amount);
        bus.alu_zero   = (bus.alu_result == 32'd0);
    end

    // One cycle: records writeback transfers and executes accepted packets on the model
    task automatic tick(output bit acc);
        logic [31:0] a, b, res;
        if (rand_ready) bus.wb_ready = 1'($urandom_range(0, 1));
        #1;
        acc = bus.in_valid && bus.in_ready && !rst;
        if (!rst && bus.wb_valid && bus.wb_ready)
            obs_q.push_back(wb_t'{bus.wb_rd, bus.wb_data, bus.wb_zero});
        if (acc) begin
            if (bus.in_op >= 4'd9) begin
                m_err = 1'b1;
            end else begin
                a   = m_regs[bus.in_rs1];
                b   = bus.in_use_imm ? bus.in_imm : m_regs[bus.in_rs2];
                res = alu_f(bus.in_op, a, b, bus.in_shamt);
                m_last_a = a;
                m_last_b = b;
                exp_q.push_back(wb_t'{bus.in_rd, res, res == 32'd0});
                if (bus.in_rd != 3'd0) m_regs[bus.in_rd] = res;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic send(input logic [3:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                        input logic [2:0] rs2, input logic use_imm, input logic [31:0] imm,
                        input logic [4:0] sh);
        bit acc = 0;
        bus.in_valid   = 1'b1;
        bus.in_op      = op;
        bus.in_rd      = rd;
        bus.in_rs1     = rs1;
        bus.in_rs2     = rs2;
        bus.in_use_imm = use_imm;
        bus.in_imm     = imm;
        bus.in_shamt   = sh;
        for (int i = 0; i < 60 && !acc; i++) tick(acc);
        bus.in_valid = 1'b0;
        if (!acc) begin
            checks++; errors++;
            $display("FAIL send_timeout: packet op=%0d rd=%0d never accepted", op, rd);
        end
    endtask

    task automatic drain();
        bit acc;
        bus.in_valid = 1'b0;
        rand_ready   = 0;
        bus.wb_ready = 1'b1;
        for (int i = 0; i < 20 && obs_q.size() < exp_q.size(); i++) tick(acc);
        tick(acc);
        tick(acc);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_regs[i] = 32'd0;
        m_err = 1'b0;
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic test_reset();
        bit acc;
        rst = 1'b1;
        bus.in_valid = 1'b0; bus.in_op = '0; bus.in_rd = '0; bus.in_rs1 = '0; bus.in_rs2 = '0;
        bus.in_use_imm = 1'b0; bus.in_imm = '0; bus.in_shamt = '0;
        bus.wb_ready = 1'b1; bus.dbg_addr = '0;
        model_reset();
        @(negedge clk);
        tick(acc);
        tick(acc);
        checks++;
        if ({bus.wb_valid, bus.alu_a, bus.alu_b, bus.alu_op_code, bus.alu_shift_amount,
             bus.wb_data, bus.err_illegal} !== '0) begin
            errors++;
            $display("FAIL reset_state: wb_valid=%b alu_a=%h alu_b=%h wb_data=%h err=%b, required all 0",
                     bus.wb_valid, bus.alu_a, bus.alu_b, bus.wb_data, bus.err_illegal);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: got %b required 1", bus.in_ready);
        end
        @(negedge clk);
    endtask

    task automatic test_forwarding();
        send(OP_ADD, 3'd1, 3'd0, 3'd0, 1'b1, 32'd5, 5'd0);
        send(OP_ADD, 3'd2, 3'd0, 3'd0, 1'b1, 32'd3, 5'd0);
        send(OP_ADD, 3'd3, 3'd1, 3'd2, 1'b0, 32'd0, 5'd0);
        checks++;
        if (bus.alu_a !== 32'd5 || bus.alu_b !== 32'd3) begin
            errors++;
            $display("FAIL fwd_add_operands: alu_a=%0d alu_b=%0d required 5 and 3", bus.alu_a, bus.alu_b);
        end
        send(OP_SUB, 3'd4, 3'd3, 3'd3, 1'b0, 32'd0, 5'd0);
        checks++;
        if (bus.alu_a !== m_last_a || bus.alu_b !== m_last_b) begin
            errors++;
            $display("FAIL fwd_sub_operands: alu_a=%0d alu_b=%0d required %0d and %0d",
                     bus.alu_a, bus.alu_b, m_last_a, m_last_b);
        end
        drain();
        checks++;
        if (obs_q.size() !== exp_q.size()) begin
            errors++;
            $display("FAIL fwd_wb_count: got %0d required %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL fwd_wb[%0d]: got rd=%0d data=%h zero=%b required rd=%0d data=%h zero=%b", i,
                         obs_q[i].rd, obs_q[i].data, obs_q[i].zero, exp_q[i].rd, exp_q[i].data, exp_q[i].zero);
            end
        end
        if (obs_q.size() == 4) begin
            checks++;
            if (obs_q[2] !== wb_t'{3'd3, 32'd8, 1'b0} || obs_q[3] !== wb_t'{3'd4, 32'd0, 1'b1}) begin
                errors++;
                $display("FAIL fwd_wb_const: got r3 data=%h zero=%b, r4 data=%h zero=%b required 8/0 and 0/1",
                         obs_q[2].data, obs_q[2].zero, obs_q[3].data, obs_q[3].zero);
            end
        end
        obs_q.delete(); exp_q.delete();
        bus.dbg_addr = 3'd3;
        #1;
        checks++;
        if (bus.dbg_data !== 32'd8) begin
            errors++;
            $display("FAIL dbg_r3: got %0d required 8", bus.dbg_data);
        end
    endtask

    task automatic test_shifts();
        logic [31:0] want [3];
        logic [2:0]  addr [3];
        want = '{32'd8, 32'd128, 32'h0000_0003};
        addr = '{3'd6, 3'd7, 3'd2};
        send(OP_ADD, 3'd5, 3'd0, 3'd0, 1'b1, 32'd32, 5'd0);
        send(OP_SRL, 3'd6, 3'd5, 3'd0, 1'b0, 32'd0, 5'd2);
        send(OP_SLL, 3'd7, 3'd5, 3'd0, 1'b0, 32'd0, 5'd2);
        send(OP_ADD, 3'd1, 3'd0, 3'd0, 1'b1, 32'h8000_0001, 5'd0);
        send(OP_ROL, 3'd2, 3'd1, 3'd0, 1'b0, 32'd0, 5'd1);
        drain();
        checks++;
        if (obs_q.size() !== exp_q.size()) begin
            errors++;
            $display("FAIL shift_wb_count: got %0d required %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL shift_wb[%0d]: got rd=%0d data=%h required rd=%0d data=%h", i,
                         obs_q[i].rd, obs_q[i].data, exp_q[i].rd, exp_q[i].data);
            end
        end
        obs_q.delete(); exp_q.delete();
        for (int i = 0; i < 3; i++) begin
            bus.dbg_addr = addr[i];
            #1;
            checks++;
            if (bus.dbg_data !== want[i]) begin
                errors++;
                $display("FAIL shift_dbg_r%0d: got %h required %h", addr[i], bus.dbg_data, want[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        bit acc;
        logic [31:0] snap_wb, snap_a;
        bus.wb_ready = 1'b0;
        send(OP_ADD, 3'd1, 3'd0, 3'd0, 1'b1, 32'd11, 5'd0);
        send(OP_XOR, 3'd2, 3'd1, 3'd0, 1'b1, 32'h0000_00ff, 5'd0);
        checks++;
        if (bus.wb_valid !== 1'b1 || bus.wb_data !== 32'd11) begin
            errors++;
            $display("FAIL bp_w_loaded: wb_valid=%b wb_data=%0d required 1 and 11", bus.wb_valid, bus.wb_data);
        end
        snap_wb = bus.wb_data;
        snap_a  = bus.alu_a;
        bus.in_valid = 1'b1; bus.in_op = OP_ADD; bus.in_rd = 3'd3; bus.in_rs1 = 3'd2;
        bus.in_rs2 = 3'd1; bus.in_use_imm = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick(acc);
            checks++;
            if (bus.in_ready !== 1'b0 || acc || bus.wb_data !== snap_wb || bus.alu_a !== snap_a) begin
                errors++;
                $display("FAIL bp_hold[%0d]: in_ready=%b wb_data=%h alu_a=%h required 0, %h, %h",
                         i, bus.in_ready, bus.wb_data, bus.alu_a, snap_wb, snap_a);
            end
        end
        bus.wb_ready = 1'b1;
        acc = 0;
        for (int i = 0; i < 10 && !acc; i++) tick(acc);
        drain();
        checks++;
        if (obs_q.size() !== 3 || exp_q.size() !== 3) begin
            errors++;
            $display("FAIL bp_wb_count: got %0d required 3", obs_q.size());
        end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL bp_wb[%0d]: got rd=%0d data=%h required rd=%0d data=%h", i,
                         obs_q[i].rd, obs_q[i].data, exp_q[i].rd, exp_q[i].data);
            end
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_illegal();
        send(4'd12, 3'd5, 3'd1, 3'd0, 1'b0, 32'd0, 5'd0);
        #1;
        checks++;
        if (bus.err_illegal !== 1'b1) begin
            errors++;
            $display("FAIL illegal_err_set: got %b required 1", bus.err_illegal);
        end
        send(OP_ADD, 3'd6, 3'd0, 3'd0, 1'b1, 32'd99, 5'd0);
        drain();
        checks++;
        if (bus.err_illegal !== 1'b1) begin
            errors++;
            $display("FAIL illegal_err_sticky: got %b required 1", bus.err_illegal);
        end
        checks++;
        if (obs_q.size() !== 1 || exp_q.size() !== 1) begin
            errors++;
            $display("FAIL illegal_wb_count: got %0d required 1", obs_q.size());
        end else begin
            checks++;
            if (obs_q[0] !== wb_t'{3'd6, 32'd99, 1'b0}) begin
                errors++;
                $display("FAIL illegal_next_wb: got rd=%0d data=%0d required rd=6 data=99",
                         obs_q[0].rd, obs_q[0].data);
            end
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_r0_and_reset();
        bit acc;
        send(OP_ADD, 3'd0, 3'd0, 3'd0, 1'b1, 32'd7, 5'd0);
        drain();
        checks++;
        if (obs_q.size() !== 1 || (obs_q.size() == 1 && obs_q[0] !== wb_t'{3'd0, 32'd7, 1'b0})) begin
            errors++;
            $display("FAIL r0_wb_pulse: got %0d transfers required one rd=0 data=7", obs_q.size());
        end
        obs_q.delete(); exp_q.delete();
        bus.dbg_addr = 3'd0;
        #1;
        checks++;
        if (bus.dbg_data !== 32'd0) begin
            errors++;
            $display("FAIL r0_dbg: got %h required 0", bus.dbg_data);
        end
        @(negedge clk);
        send(OP_ADD, 3'd1, 3'd0, 3'd0, 1'b1, 32'd1, 5'd0);
        send(OP_ADD, 3'd2, 3'd0, 3'd0, 1'b1, 32'd2, 5'd0);
        rst = 1'b1;
        #1;
        checks++;
        if (bus.wb_valid !== 1'b0 || bus.err_illegal !== 1'b0 || bus.alu_a !== 32'd0) begin
            errors++;
            $display("FAIL midrst_state: wb_valid=%b err=%b alu_a=%h required 0", bus.wb_valid,
                     bus.err_illegal, bus.alu_a);
        end
        for (int i = 0; i < 8; i++) begin
            bus.dbg_addr = 3'(i);
            #1;
            checks++;
            if (bus.dbg_data !== 32'd0) begin
                errors++;
                $display("FAIL midrst_dbg_r%0d: got %h required 0", i, bus.dbg_data);
            end
        end
        model_reset();
        @(negedge clk);
        tick(acc);
        rst = 1'b0;
        tick(acc);
    endtask

    task automatic test_random();
        bit acc;
        rand_ready = 1;
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 7) == 0) tick(acc);
            send(($urandom_range(0, 19) == 0) ? 4'd13 : 4'($urandom_range(0, 8)),
                 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                 1'($urandom_range(0, 1)), $urandom, 5'($urandom_range(0, 31)));
            rand_ready = 1;
        end
        drain();
        checks++;
        if (obs_q.size() !== exp_q.size()) begin
            errors++;
            $display("FAIL rand_wb_count: got %0d required %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL rand_wb[%0d]: got rd=%0d data=%h zero=%b required rd=%0d data=%h zero=%b", i,
                         obs_q[i].rd, obs_q[i].data, obs_q[i].zero, exp_q[i].rd, exp_q[i].data, exp_q[i].zero);
            end
        end
        obs_q.delete(); exp_q.delete();
        for (int i = 0; i < 8; i++) begin
            bus.dbg_addr = 3'(i);
            #1;
            checks++;
            if (bus.dbg_data !== m_regs[i]) begin
                errors++;
                $display("FAIL rand_dbg_r%0d: got %h required %h", i, bus.dbg_data, m_regs[i]);
            end
        end
        checks++;
        if (bus.err_illegal !== m_err) begin
            errors++;
            $display("FAIL rand_err: got %b required %b", bus.err_illegal, m_err);
        end
    endtask

    initial begin
        test_reset();
        test_forwarding();
        test_shifts();
        test_backpressure();
        test_illegal();
        test_r0_and_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
